// File: rtl/conv1d_pkg.sv
// Shared definitions for the Conv1D multiply-accumulate unit: default
// geometry, controller state encoding and the output post-processing
// (arithmetic shift, optional ReLU, signed saturation).
package conv1d_pkg;

   localparam int DEF_KERNEL_SIZE = 3;
   localparam int DEF_DATA_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACCUM      = 2'd1,
      WAIT_WRITE = 2'd2,
      COMMIT     = 2'd3
   } state_t;

   // Post-processes a sign-extended accumulator value. The result always lies
   // inside the signed range of out_width bits, so the caller may simply keep
   // the low out_width bits.
   function automatic logic signed [63:0] post_process(
      input logic signed [63:0] sum,
      input int                 shift,
      input logic               relu,
      input int                 out_width
   );
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v  = sum >>> shift;
      if (relu && (v < 64'sd0)) begin
         v = 64'sd0;
      end
      hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_width - 1));
      if (v > hi) begin
         v = hi;
      end else if (v < lo) begin
         v = lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/conv1d_mac_pipe.sv
// Arithmetic half of the Conv1D MAC unit. A tap-valid delay line follows each
// issued tap address through the buffer read latency; the aligned sample pair
// is multiplied into a product register and then added into the accumulator.
module conv1d_mac_pipe #(
   parameter int DATA_WIDTH   = 8,
   parameter int ACC_WIDTH    = 20,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  tap_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic                  pending
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   // Stage i is high when the tap issued i+1 cycles ago is at that point of
   // the pipe: stage READ_LATENCY-1 lines up with the buffer read data and
   // stage READ_LATENCY with the product register.
   logic [READ_LATENCY:0]         tap_vld;
   logic signed [PROD_WIDTH-1:0]  prod;

   // Tap-valid delay line; a flush drops every tap still in flight.
   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of its neighbours, which is what makes a shift chain work.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         tap_vld <= '0;
      end else begin
         tap_vld <= {tap_vld[READ_LATENCY-1:0], tap_en};
      end
   end

   // Product register: captures the signed product of the aligned samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
      end else if (tap_vld[READ_LATENCY-1]) begin
         prod <= PROD_WIDTH'($signed(w_data)) * PROD_WIDTH'($signed(x_data));
      end
   end

   // Accumulator: adds each registered product, wrapping modulo 2^ACC_WIDTH.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         acc <= '0;
      end else if (tap_vld[READ_LATENCY]) begin
         acc <= acc + ACC_WIDTH'(prod);
      end
   end

   assign pending = |tap_vld;

endmodule

// File: rtl/conv1d_mac_unit.sv
// Conv1D multiply-accumulate stage. Follows the address generator's
// clear/valid/write sequence, runs one K-tap MAC per window in the
// conv1d_mac_pipe datapath and commits the post-processed sum to the output
// buffer with a single write pulse. Protocol violations raise a sticky flag.
module conv1d_mac_unit
   import conv1d_pkg::*;
#(
   parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH    = 20,
   parameter int OUT_WIDTH    = 8,
   parameter int OUT_SHIFT    = 0,
   parameter int RELU         = 0,
   parameter int ADDR_BITS    = 5,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  valid,
   input  logic                  write,
   input  logic [ADDR_BITS-1:0]  out_address,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [DATA_WIDTH-1:0] x_data,
   output logic                  out_we,
   output logic [ADDR_BITS-1:0]  out_addr,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  busy,
   output logic                  seq_err
);

   localparam int                CNT_W = $clog2(KERNEL_SIZE + 1);
   localparam logic [CNT_W-1:0]  TAPS  = CNT_W'(KERNEL_SIZE);

   state_t                 state;
   logic [CNT_W-1:0]       tap_cnt;
   logic                   valid_seen;
   logic                   write_seen;
   logic [ADDR_BITS-1:0]   addr_q;

   logic                   tap_en;
   logic                   pending;
   logic                   err_now;
   logic [ACC_WIDTH-1:0]   acc;

   // One tap address is outstanding per ACCUM cycle until K have gone out.
   assign tap_en = (state == ACCUM) && (tap_cnt != TAPS);

   // A clear in any state starts a fresh window, so it also wipes the pipe.
   conv1d_mac_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (clear),
      .tap_en  (tap_en),
      .w_data  (w_data),
      .x_data  (x_data),
      .acc     (acc),
      .pending (pending)
   );

   // Protocol check: a strobe that arrives where the generator never sends it.
   // NOTE: err_now gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold it.
   always_comb begin
      err_now = 1'b0;
      case (state)
         IDLE:    err_now = valid || write;
         ACCUM:   err_now = (valid && (tap_cnt != TAPS)) || (write && !valid_seen);
         default: err_now = 1'b0;
      endcase
   end

   // Window controller with registered outputs. The write pulse, address and
   // data are all loaded on the edge that enters COMMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tap_cnt    <= '0;
         valid_seen <= 1'b0;
         write_seen <= 1'b0;
         addr_q     <= '0;
         out_we     <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         busy       <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         out_we <= 1'b0;
         if (err_now) begin
            seq_err <= 1'b1;
         end
         if (clear) begin
            // New window, or abort of the current one without a write.
            state      <= ACCUM;
            tap_cnt    <= '0;
            valid_seen <= 1'b0;
            write_seen <= 1'b0;
            busy       <= 1'b1;
         end else begin
            case (state)
               ACCUM: begin
                  if (tap_en) begin
                     tap_cnt <= tap_cnt + 1'b1;
                  end
                  // valid follows the last tap; an early one is ignored.
                  if (valid && (tap_cnt == TAPS)) begin
                     addr_q     <= out_address;
                     valid_seen <= 1'b1;
                  end
                  if (write && valid_seen) begin
                     write_seen <= 1'b1;
                  end
                  // Stay one cycle after the last tap so valid lands here.
                  if (tap_cnt == TAPS) begin
                     state <= WAIT_WRITE;
                  end
               end
               WAIT_WRITE: begin
                  if (!pending && (write_seen || write)) begin
                     state    <= COMMIT;
                     out_we   <= 1'b1;
                     out_addr <= addr_q;
                     out_data <= OUT_WIDTH'(post_process(64'($signed(acc)), OUT_SHIFT,
                                                         (RELU != 0), OUT_WIDTH));
                     busy     <= 1'b0;
                  end else if (write) begin
                     // write overtook the pipe drain; remember it.
                     write_seen <= 1'b1;
                  end
               end
               COMMIT: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
